// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU definitions. It holds the default program-counter
//                width and the hardware call-stack operation encoding. The
//                encoding matches the {push, pop} strobe pair directly.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Default program-counter width, in bits.
    localparam int c_pc_w = 13;

    // Stack operation. Each value equals the {push, pop} strobe pair.
    typedef enum logic [1:0] {
        STK_NOP     = 2'b00,
        STK_PUSH    = 2'b10,
        STK_POP     = 2'b01,
        STK_REPLACE = 2'b11
    } stk_op_t;

    function automatic stk_op_t stk_decode(input logic push, input logic pop);
        return stk_op_t'({push, pop});
    endfunction

endpackage
`default_nettype wire

// File: rtl/stack_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : stack_ptr
//  Description : Top-of-stack pointer and level counter for call_stack.
//                Pointer arithmetic is modulo DEPTH. The level saturates
//                at 0 and at DEPTH. The module also tells the storage array
//                where to write and when.
//  Macro       : CALL_STACK_WRAP_EN - when defined, a push to a full stack
//                overwrites the oldest entry (circular stack). When
//                undefined, a push to a full stack is ignored.
//  Ports       : clk, reset     - clock, synchronous active-high reset
//                op             - stack operation (cpu_pkg::stk_op_t)
//                top_ptr        - index of the current top entry
//                wr_en, wr_ptr  - storage write strobe and index
//                level          - number of valid entries
//                empty, full    - level == 0 / level == DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_ptr
    import cpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       op,
    output logic [PTR_W-1:0] top_ptr,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [LVL_W-1:0] level,
    output logic             empty,
    output logic             full
);

    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] c_depth    = LVL_W'(DEPTH);

    logic [PTR_W-1:0] r_top_ptr;
    logic [LVL_W-1:0] r_level;
    logic [PTR_W-1:0] w_next_ptr;
    logic [PTR_W-1:0] w_prev_ptr;
    logic [PTR_W-1:0] w_top_nxt;
    logic [LVL_W-1:0] w_lvl_nxt;
    logic             w_empty;
    logic             w_full;
    stk_op_t          w_op;

    assign w_op    = stk_op_t'(op);
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_depth);

    // The modulo step is written as an explicit compare so that DEPTH
    // values that are not a power of two also wrap correctly.
    assign w_next_ptr = (r_top_ptr == c_last_ptr) ? '0 : r_top_ptr + 1'b1;
    assign w_prev_ptr = (r_top_ptr == '0) ? c_last_ptr : r_top_ptr - 1'b1;

    always_comb begin
        w_top_nxt = r_top_ptr;
        w_lvl_nxt = r_level;
        wr_en     = 1'b0;
        wr_ptr    = w_next_ptr;
        case (w_op)
            STK_PUSH: begin
                if (!w_full) begin
                    wr_en     = 1'b1;
                    w_top_nxt = w_next_ptr;
                    w_lvl_nxt = r_level + 1'b1;
                end else begin
`ifdef CALL_STACK_WRAP_EN
                    // When the stack is full, the slot above the top holds the
                    // oldest entry. Overwriting it gives circular behaviour.
                    wr_en     = 1'b1;
                    w_top_nxt = w_next_ptr;
`endif
                end
            end
            STK_POP: begin
                if (!w_empty) begin
                    w_top_nxt = w_prev_ptr;
                    w_lvl_nxt = r_level - 1'b1;
                end
            end
            STK_REPLACE: begin
                if (!w_empty) begin
                    wr_en  = 1'b1;
                    wr_ptr = r_top_ptr;
                end else begin
                    // On an empty stack, a replace behaves as a plain push.
                    wr_en     = 1'b1;
                    w_top_nxt = w_next_ptr;
                    w_lvl_nxt = r_level + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // After reset the top sits on the last slot, so the first push lands
    // in slot 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_top_ptr <= c_last_ptr;
            r_level   <= '0;
        end else begin
            r_top_ptr <= w_top_nxt;
            r_level   <= w_lvl_nxt;
        end
    end

    assign top_ptr = r_top_ptr;
    assign level   = r_level;
    assign empty   = w_empty;
    assign full    = w_full;

endmodule
`default_nettype wire

// File: rtl/call_stack.sv
`default_nettype none
// ============================================================================
//  Module      : call_stack
//  Description : Hardware return-address stack for a small CPU core.
//                - push stores an address.
//                - pop discards the top entry. The popped value is visible
//                  on top_addr during the pop cycle.
//                - push and pop together replace the top entry.
//                - Sticky overflow and underflow flags are cleared by err_clr.
//  Macro       : CALL_STACK_WRAP_EN - when defined, the stack is circular and
//                a push while full overwrites the oldest entry. When
//                undefined, a push while full is dropped.
//  Ports       : clk, reset           - clock, synchronous active-high reset
//                push, pop, push_addr - operation strobes and address to store
//                err_clr              - clears overflow/underflow
//                top_addr             - current top entry (zero when empty)
//                level, empty, full   - occupancy
//                overflow, underflow  - sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module call_stack
    import cpu_pkg::*;
#(
    parameter int ADDR_W = c_pc_w,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic                       err_clr,
    output logic [ADDR_W-1:0]          top_addr,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_lvl_w = $clog2(DEPTH + 1);

    // Storage is not reset. The level alone decides which entries are valid.
    logic [ADDR_W-1:0]  r_mem [DEPTH];
    logic               r_overflow;
    logic               r_underflow;
    stk_op_t            w_op;
    logic [c_ptr_w-1:0] w_top_ptr;
    logic [c_ptr_w-1:0] w_wr_ptr;
    logic               w_wr_en;
    logic [c_lvl_w-1:0] w_level;
    logic               w_empty;
    logic               w_full;
    logic               w_ovf_set;
    logic               w_unf_set;

    assign w_op = stk_decode(push, pop);

    stack_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (c_ptr_w),
        .LVL_W (c_lvl_w)
    ) u_stack_ptr (
        .clk     (clk),
        .reset   (reset),
        .op      (w_op),
        .top_ptr (w_top_ptr),
        .wr_en   (w_wr_en),
        .wr_ptr  (w_wr_ptr),
        .level   (w_level),
        .empty   (w_empty),
        .full    (w_full)
    );

    always_ff @(posedge clk) begin
        if (w_wr_en && !reset) begin
            r_mem[w_wr_ptr] <= push_addr;
        end
    end

    // Only a plain push or a plain pop can raise a flag. A replace never
    // raises one.
    assign w_ovf_set = (w_op == STK_PUSH) && w_full;
    assign w_unf_set = (w_op == STK_POP)  && w_empty;

    // A new error in the same cycle wins over err_clr.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign top_addr  = w_empty ? '0 : r_mem[w_top_ptr];
    assign level     = w_level;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: doc/call_stack.md
CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 Parameter ADDR_W, default 13, width of a stored program-counter address.
REQ-002 Parameter DEPTH, default 8, number of stack entries, any integer 2..64.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 push  input  1  store push_addr as new top this cycle.
REQ-006 pop  input  1  discard top entry this cycle.
REQ-007 push_addr  input  ADDR_W  return address to store, normally PC+1.
REQ-008 err_clr  input  1  clears sticky overflow/underflow flags.
REQ-009 top_addr  output  ADDR_W  current top entry, combinational from registered state.
REQ-010 level  output  $clog2(DEPTH+1)  number of valid entries.
REQ-011 empty  output  1  high when level == 0.
REQ-012 full  output  1  high when level == DEPTH.
REQ-013 overflow  output  1  sticky, push attempted while full.
REQ-014 underflow  output  1  sticky, pop attempted while empty.

Function
REQ-015 Operation SHALL be decoded per cycle from {push,pop}: 00 hold, 10 push, 01 pop, 11 replace.
REQ-016 Push with level < DEPTH SHALL write push_addr above the current top and increment level at the edge.
REQ-017 Pop with level > 0 SHALL decrement level at the edge; the popped value SHALL be presented on top_addr during the cycle pop is asserted, so the PC loads it with zero added latency.
REQ-018 top_addr SHALL be all-zero whenever empty is high.
REQ-019 Replace (push and pop together) with level > 0 SHALL overwrite the top with push_addr, leaving level unchanged; no flag is set, including when full.
REQ-020 Replace with level == 0 SHALL act as a plain push; underflow is not set.
REQ-021 Pop with level == 0 SHALL leave all state unchanged and set underflow at the edge.
REQ-022 Push with level == DEPTH SHALL set overflow at the edge; data behaviour per Configuration.
REQ-023 err_clr SHALL clear both flags at the edge; a new error in the same cycle takes precedence, and the flag stays set.
REQ-024 Entries below the top SHALL never change except through the overwrite-oldest path of REQ-030.
REQ-025 Pointer arithmetic SHALL be modulo DEPTH; level SHALL never exceed DEPTH nor go below 0.

Reset
REQ-026 reset SHALL take priority over all other inputs in the same cycle.
REQ-027 After reset: level=0, empty=1, full=0, overflow=0, underflow=0, top_addr=0.
REQ-028 Reset asserted mid-sequence SHALL discard all entries; storage contents need not be cleared, since validity is tracked by level alone.

Configuration
REQ-029 Macro CALL_STACK_WRAP_EN SHALL select full-stack push behaviour.
REQ-030 Defined: push while full SHALL overwrite the oldest entry, make push_addr the new top, keep level = DEPTH and still set overflow; this is the circular, PIC16-compatible stack.
REQ-031 Undefined: push while full SHALL be ignored, leaving storage and level unchanged, and SHALL set overflow.

Structure
REQ-032 Shared package cpu_pkg SHALL hold the default PC width constant (13) and the stack-op enum {STK_NOP, STK_PUSH, STK_POP, STK_REPLACE}.
REQ-033 Sub-module stack_ptr SHALL own the top pointer and level counter, including wrap and saturation; call_stack owns the storage array and flags.
REQ-034 Storage SHALL be a register array of DEPTH x ADDR_W with no reset on the data.

Verification (DEPTH=8, ADDR_W=13)
REQ-035 Reset, then push 0x0011, 0x0022, 0x0033 -> level=3, top_addr=0x0033; pop x3 -> tops seen 0x0033, 0x0022, 0x0011, then empty=1, top_addr=0.
REQ-036 Pop while empty -> level stays 0, underflow=1; err_clr for one cycle -> underflow=0.
REQ-037 Push 0x0100..0x0108 (9 pushes) -> full=1 after the 8th push, overflow=1 after the 9th; WRAP_EN: top=0x0108 and eight pops yield 0x0108..0x0101; no WRAP_EN: top=0x0107 and eight pops yield 0x0107..0x0100.
REQ-038 Level 2 with top 0x0AAA, push+pop with 0x0BBB -> level=2, top=0x0BBB; pop -> top=previous entry.
REQ-039 Level 5, then reset asserted together with push -> level=0, empty=1, flags 0; the next push of 0x1FFF -> top=0x1FFF, level=1.
REQ-040 Pop and err_clr in the same cycle while empty -> underflow remains 1.
